// File: rtl/conv_mac_seq.sv
// Conv-layer MAC sequencer: row-major output scan, KxK taps per pixel, valid/ready result.
// Optional `CONV_MAC_SEQ_RELU_EN fuses a ReLU into the result capture.
module conv_mac_seq #(
    parameter int IN_W      = 32,
    parameter int IN_H      = 32,
    parameter int K         = 5,
    parameter int O_CONV_BW = 20
) (
    input  logic                         clk,
    input  logic                         global_rst,
    input  logic                         start,
    input  logic                         clear,
    output logic [$clog2(IN_W*IN_H)-1:0] in_addr,
    output logic [$clog2(K*K)-1:0]       w_addr,
    output logic                         mac_ce,
    output logic                         mac_first,
    output logic                         mac_self_rst,
    input  logic [O_CONV_BW-1:0]         mac_o_data,
    output logic [O_CONV_BW-1:0]         o_data,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic                         busy,
    output logic                         done
);

    localparam int TAPS  = K * K;
    localparam int OUT_W = IN_W - K + 1;
    localparam int OUT_H = IN_H - K + 1;
    localparam int AW    = $clog2(IN_W * IN_H);
    localparam int WW    = $clog2(TAPS);
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [CW-1:0] C_LAST = CW'(OUT_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(OUT_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CAP,
        S_OUT,
        S_DONE
    } state_t;

    state_t               state;
    logic [KW-1:0]        tr;
    logic [KW-1:0]        tc;
    logic [CW-1:0]        ocol;
    logic [RW-1:0]        orow;
    logic [AW-1:0]        row_a;
    logic [AW-1:0]        col_a;
    logic [O_CONV_BW-1:0] cap_d;

    assign row_a   = AW'(orow) + AW'(tr);
    assign col_a   = AW'(ocol) + AW'(tc);
    assign in_addr = row_a * AW'(IN_W) + col_a;
    assign w_addr  = WW'(tr) * WW'(K) + WW'(tc);

    assign mac_ce    = (state == S_RUN);
    assign mac_first = mac_ce && (tr == '0) && (tc == '0);
    assign busy      = (state != S_IDLE);

`ifdef CONV_MAC_SEQ_RELU_EN
    assign cap_d = mac_o_data[O_CONV_BW-1] ? '0 : mac_o_data;
`else
    assign cap_d = mac_o_data;
`endif

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            state        <= S_IDLE;
            tr           <= '0;
            tc           <= '0;
            ocol         <= '0;
            orow         <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            done         <= 1'b0;
            mac_self_rst <= 1'b0;
        end else if (clear) begin
            state        <= S_IDLE;
            tr           <= '0;
            tc           <= '0;
            ocol         <= '0;
            orow         <= '0;
            o_valid      <= 1'b0;
            done         <= 1'b0;
            mac_self_rst <= 1'b1;
        end else begin
            mac_self_rst <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) state <= S_RUN;
                end
                S_RUN: begin
                    if (tc == K_LAST) begin
                        tc <= '0;
                        if (tr == K_LAST) begin
                            tr    <= '0;
                            state <= S_CAP;
                        end else begin
                            tr <= tr + 1'b1;
                        end
                    end else begin
                        tc <= tc + 1'b1;
                    end
                end
                S_CAP: begin
                    o_data  <= cap_d;
                    o_valid <= 1'b1;
                    state   <= S_OUT;
                end
                S_OUT: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        if (ocol == C_LAST) begin
                            ocol <= '0;
                            if (orow == R_LAST) begin
                                orow  <= '0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                orow  <= orow + 1'b1;
                                state <= S_RUN;
                            end
                        end else begin
                            ocol  <= ocol + 1'b1;
                            state <= S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Bench for conv_mac_seq on a 6x6 map, K=3, with a behavioural accumulating MAC.
// Results are scoreboarded; timing, addresses, backpressure, clear and reset are spot-checked.
module tb_conv_mac_seq;

    localparam int IW   = 6;
    localparam int IH   = 6;
    localparam int KK   = 3;
    localparam int BW   = 20;
    localparam int OW   = IW - KK + 1;
    localparam int OH   = IH - KK + 1;
    localparam int NPIX = OW * OH;

`ifdef CONV_MAC_SEQ_RELU_EN
    localparam logic [BW-1:0] NEG_EXP = '0;
`else
    localparam logic [BW-1:0] NEG_EXP = 20'hFFFDC;
`endif

    logic          clk = 1'b0;
    logic          global_rst = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          o_ready = 1'b1;
    logic [5:0]    in_addr;
    logic [3:0]    w_addr;
    logic          mac_ce;
    logic          mac_first;
    logic          mac_self_rst;
    logic [BW-1:0] mac_o_data;
    logic [BW-1:0] o_data;
    logic          o_valid;
    logic          busy;
    logic          done;

    logic signed [BW-1:0] acc;
    int            xmem [64];
    int            wmem [16];
    int            vecs = 0;
    int            errs = 0;
    int            done_cnt = 0;
    logic [BW-1:0] sbq [$];

    conv_mac_seq #(
        .IN_W(IW), .IN_H(IH), .K(KK), .O_CONV_BW(BW)
    ) dut (
        .clk(clk),
        .global_rst(global_rst),
        .start(start),
        .clear(clear),
        .in_addr(in_addr),
        .w_addr(w_addr),
        .mac_ce(mac_ce),
        .mac_first(mac_first),
        .mac_self_rst(mac_self_rst),
        .mac_o_data(mac_o_data),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Accumulating MAC: register holds the running sum, tap 0 restarts it.
    always @(posedge clk or posedge global_rst) begin
        if (global_rst)
            acc <= '0;
        else if (mac_self_rst)
            acc <= '0;
        else if (mac_ce)
            acc <= (mac_first ? '0 : acc)
                 + BW'(xmem[in_addr] * wmem[w_addr]);
    end
    assign mac_o_data = acc;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!global_rst && o_valid && o_ready) begin
            if (sbq.size() == 0)
                chk("sb_extra", 32'(sbq.size()), 32'd1);
            else
                chk("pix", 32'(o_data), 32'(sbq.pop_front()));
        end
        if (done) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(int mode);
        for (int i = 0; i < 64; i++)
            xmem[i] = (mode == 0) ? 1 : (mode == 1) ? ((i * 5) % 11) - 5 : 4;
        for (int t = 0; t < 16; t++)
            wmem[t] = (mode == 0) ? 1 : (mode == 1) ? t - 4 : -1;
    endtask

    function automatic logic [BW-1:0] model(int r, int c);
        int s = 0;
        for (int a = 0; a < KK; a++)
            for (int b = 0; b < KK; b++)
                s += xmem[(r + a) * IW + c + b] * wmem[a * KK + b];
`ifdef CONV_MAC_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        return BW'(s);
    endfunction

    task automatic push_const(int n, logic [BW-1:0] v);
        for (int i = 0; i < n; i++) sbq.push_back(v);
    endtask

    task automatic push_model;
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                sbq.push_back(model(r, c));
    endtask

    // Leaves the bench in cycle 1 (first tap cycle).
    task automatic start_pulse;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick;
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        tick;
    endtask

    task automatic wait_valid(int bound);
        int n = 0;
        while (!o_valid && n < bound) begin
            tick;
            n++;
        end
        chk("valid_seen", 32'(o_valid), 32'd1);
    endtask

    initial begin
        int n, first, prev, per_bad, mf_bad, ce, done_n, d0;
        logic [BW-1:0] hd;

        set_data(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_oval", 32'(o_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ce", 32'(mac_ce), 0);
        chk("rst_first", 32'(mac_first), 0);
        chk("rst_srst", 32'(mac_self_rst), 0);
        chk("rst_iaddr", 32'(in_addr), 0);
        chk("rst_waddr", 32'(w_addr), 0);
        chk("rst_odata", 32'(o_data), 0);
        global_rst = 1'b0;
        tick;

        // All-ones frame: timing, addresses, mac_first
        push_const(NPIX, 20'd9);
        d0 = done_cnt;
        first = 0; prev = 0; per_bad = 0; mf_bad = 0; ce = 0; done_n = 0;
        start_pulse;
        for (n = 1; n <= 180; n++) begin
            if (o_valid) begin
                if (first == 0) first = n;
                else if (n - prev != 11) per_bad++;
                prev = n;
            end
            if (mac_ce) begin
                ce++;
                if (mac_first != (w_addr == 4'd0)) mf_bad++;
            end
            if (n == 74) begin
                chk("sweep_iaddr", 32'(in_addr), 32'd21);
                chk("sweep_waddr", 32'(w_addr), 32'd7);
                chk("sweep_first", 32'(mac_first), 0);
            end
            if (done) done_n = n;
            tick;
        end
        chk("first_valid", 32'(first), 32'd11);
        chk("period_bad", 32'(per_bad), 0);
        chk("mac_first_bad", 32'(mf_bad), 0);
        chk("tap_count", 32'(ce), 32'd144);
        chk("done_cycle", 32'(done_n), 32'd177);
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("idle_busy", 32'(busy), 0);

        // Mixed-sign data against the convolution model
        set_data(1);
        push_model;
        d0 = done_cnt;
        start_pulse;
        wait_done(300);
        chk("pat_done", 32'(done_cnt - d0), 32'd1);

        // Negative sum: -1 * 4 over 9 taps
        set_data(2);
        push_const(NPIX, NEG_EXP);
        start_pulse;
        wait_done(300);

        // Backpressure on pixel 0
        set_data(0);
        push_const(NPIX, 20'd9);
        o_ready = 1'b0;
        start_pulse;
        wait_valid(30);
        hd = o_data;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_data", 32'(o_data), 32'(hd));
            chk("bp_ce", 32'(mac_ce), 0);
        end
        tick;
        chk("bp_valid6", 32'(o_valid), 32'd1);
        o_ready = 1'b1;
        tick;
        chk("bp_resume_ce", 32'(mac_ce), 32'd1);
        chk("bp_resume_iaddr", 32'(in_addr), 32'd1);
        chk("bp_resume_waddr", 32'(w_addr), 0);
        chk("bp_resume_first", 32'(mac_first), 32'd1);
        chk("bp_resume_oval", 32'(o_valid), 0);
        wait_done(300);

        // clear at tap 4 of pixel 3
        push_const(3, 20'd9);
        d0 = done_cnt;
        start_pulse;
        repeat (37) tick;
        chk("clr_pre_waddr", 32'(w_addr), 32'd4);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("clr_busy", 32'(busy), 0);
        chk("clr_srst", 32'(mac_self_rst), 32'd1);
        chk("clr_ce", 32'(mac_ce), 0);
        chk("clr_oval", 32'(o_valid), 0);
        tick;
        chk("clr_srst_1cyc", 32'(mac_self_rst), 0);
        repeat (5) tick;
        chk("clr_no_done", 32'(done_cnt - d0), 0);
        chk("clr_sb_empty", 32'(sbq.size()), 0);

        // Restart from pixel 0, then async reset while in OUT
        o_ready = 1'b0;
        start_pulse;
        chk("rs_iaddr", 32'(in_addr), 0);
        chk("rs_waddr", 32'(w_addr), 0);
        chk("rs_first", 32'(mac_first), 32'd1);
        chk("rs_ce", 32'(mac_ce), 32'd1);
        wait_valid(30);
        global_rst = 1'b1;
        #1;
        chk("ar_oval", 32'(o_valid), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_odata", 32'(o_data), 0);
        chk("ar_ce", 32'(mac_ce), 0);
        chk("ar_done", 32'(done), 0);
        tick;
        tick;
        global_rst = 1'b0;
        tick;
        chk("ar_no_done", 32'(done_cnt - d0), 0);

        // start while busy is ignored
        o_ready = 1'b1;
        push_const(NPIX, 20'd9);
        d0 = done_cnt;
        start_pulse;
        repeat (4) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("sb_waddr", 32'(w_addr), 32'd5);
        chk("sb_first", 32'(mac_first), 0);
        wait_done(300);
        chk("sb_done", 32'(done_cnt - d0), 32'd1);

        // start and clear together in IDLE
        tick;
        start = 1'b1;
        clear = 1'b1;
        tick;
        start = 1'b0;
        clear = 1'b0;
        chk("sc_busy", 32'(busy), 0);
        chk("sc_ce", 32'(mac_ce), 0);
        chk("sc_srst", 32'(mac_self_rst), 32'd1);
        repeat (3) tick;
        chk("sc_busy_late", 32'(busy), 0);
        chk("sb_drain", 32'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
